// File: rtl/rca_config_pkg.sv
// Shared geometry, instruction encodings and per-RCA configuration layout for the RCA config path.
package rca_config;

    localparam int unsigned NUM_RCAS           = 4;
    localparam int unsigned NUM_READ_PORTS     = 5;
    localparam int unsigned NUM_WRITE_PORTS    = 5;
    localparam int unsigned NUM_GRID_MUXES     = 72;
    localparam int unsigned GRID_MUX_INPUTS    = 8;
    localparam int unsigned NUM_IO_UNITS       = 14;
    localparam int unsigned IO_UNIT_MUX_INPUTS = 12;

    localparam int unsigned GRID_MUX_SEL_W = 3;
    localparam int unsigned IO_MUX_SEL_W   = 4;
    localparam int unsigned RES_MUX_SEL_W  = 4;
    localparam int unsigned REG_ADDR_W     = 5;

    // Result MUXes pick among the IO-unit outputs.
    localparam int unsigned RES_MUX_INPUTS = NUM_IO_UNITS;

    typedef enum logic [2:0] {
        RCA_USE_FB  = 3'b000,
        CPU_REG     = 3'b001,
        GRID_MUX    = 3'b010,
        IO_MUX      = 3'b011,
        RES_MUX     = 3'b100,
        IO_USE      = 3'b101,
        RCA_USE_NFB = 3'b110
    } rca_funct3_t;

    typedef struct packed {
        logic [NUM_READ_PORTS-1:0][REG_ADDR_W-1:0]      src;
        logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0]     dst_fb;
        logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0]     dst_nfb;
        logic [NUM_GRID_MUXES-1:0][GRID_MUX_SEL_W-1:0]  grid;
        logic [NUM_IO_UNITS-1:0][IO_MUX_SEL_W-1:0]      io;
        logic [NUM_WRITE_PORTS-1:0][RES_MUX_SEL_W-1:0]  res_fb;
        logic [NUM_WRITE_PORTS-1:0][RES_MUX_SEL_W-1:0]  res_nfb;
        logic [NUM_IO_UNITS-1:0]                        io_use;
    } rca_cfg_t;

    function automatic logic cfg_is_legal(input logic [2:0]  funct3,
                                          input logic [6:0]  funct7,
                                          input logic [31:0] rs1,
                                          input logic [3:0]  rs2);
        logic ok;
        case (funct3)
            CPU_REG:  ok = 32'(rs1[2:0]) < (rs1[3] ? NUM_READ_PORTS : NUM_WRITE_PORTS);
            GRID_MUX: ok = (rs1 < NUM_GRID_MUXES) && (32'(rs2[2:0]) < GRID_MUX_INPUTS);
            IO_MUX:   ok = (rs1 < NUM_IO_UNITS) && (32'(rs2) < IO_UNIT_MUX_INPUTS);
            RES_MUX:  ok = (32'(rs1[2:0]) < NUM_WRITE_PORTS) && (32'(rs2) < RES_MUX_INPUTS);
            IO_USE:   ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        return ok && (32'(funct7) < NUM_RCAS);
    endfunction

endpackage

// File: rtl/rca_config_unit_inflight_counter.sv
// Saturating up/down counter of RCA-use instructions in flight on one RCA.
module rca_inflight_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    logic [CNT_W-1:0] count_q, count_d;

    assign full_o  = &count_q;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !full_o) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rca_config_unit.sv
// RCA configuration unit: applies config instructions once the target RCA has drained its uses.
// Define RCA_CFG_READBACK_EN to add cfg_old_data (pre-write field value during the response).
module rca_config_unit
    import rca_config::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              issue_valid,
    output logic                                              issue_ready,
    input  logic [2:0]                                        issue_funct3,
    input  logic [6:0]                                        issue_funct7,
    input  logic [31:0]                                       issue_rs1,
    input  logic [31:0]                                       issue_rs2,
    input  logic                                              use_start,
    input  logic [1:0]                                        use_start_rca,
    input  logic                                              use_done,
    input  logic [1:0]                                        use_done_rca,
    output logic [NUM_RCAS-1:0]                               rca_lock,
    output logic [NUM_RCAS-1:0]                               rca_full,
    output logic                                              cfg_done,
    output logic                                              cfg_illegal,
    output logic [NUM_RCAS*NUM_READ_PORTS*REG_ADDR_W-1:0]     src_reg_addr,
    output logic [NUM_RCAS*NUM_WRITE_PORTS*REG_ADDR_W-1:0]    dst_reg_addr_fb,
    output logic [NUM_RCAS*NUM_WRITE_PORTS*REG_ADDR_W-1:0]    dst_reg_addr_nfb,
    output logic [NUM_RCAS*NUM_GRID_MUXES*GRID_MUX_SEL_W-1:0] grid_mux_sel,
    output logic [NUM_RCAS*NUM_IO_UNITS*IO_MUX_SEL_W-1:0]     io_mux_sel,
    output logic [NUM_RCAS*NUM_WRITE_PORTS*RES_MUX_SEL_W-1:0] res_mux_sel_fb,
    output logic [NUM_RCAS*NUM_WRITE_PORTS*RES_MUX_SEL_W-1:0] res_mux_sel_nfb,
    output logic [NUM_RCAS*NUM_IO_UNITS-1:0]                  io_in_use
`ifdef RCA_CFG_READBACK_EN
    ,
    output logic [31:0]                                       cfg_old_data
`endif
);

    typedef enum logic [1:0] {StIdle, StDrain, StWrite, StResp} state_e;

    state_e                             state_q, state_d;
    logic [2:0]                         f3_q, f3_d;
    logic [6:0]                         f7_q, f7_d;
    logic [13:0]                        rs1_q, rs1_d;
    logic [4:0]                         rs2_q, rs2_d;
    logic                               illegal_q, illegal_d;
    rca_cfg_t [NUM_RCAS-1:0]            cfg_q, cfg_d;
    logic [NUM_RCAS-1:0][CNT_W-1:0]     cnt;

    logic [1:0] rca;
    logic [2:0] port;
    logic unused_rs2;

    assign unused_rs2  = ^issue_rs2[31:5];
    assign rca         = f7_q[1:0];
    assign port        = rs1_q[2:0];
    assign issue_ready = (state_q == StIdle);
    assign cfg_done    = (state_q == StResp);
    assign cfg_illegal = (state_q == StResp) && illegal_q;

    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        f7_d      = f7_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (issue_valid) begin
                    f3_d      = issue_funct3;
                    f7_d      = issue_funct7;
                    rs1_d     = issue_rs1[13:0];
                    rs2_d     = issue_rs2[4:0];
                    illegal_d = !cfg_is_legal(issue_funct3, issue_funct7, issue_rs1,
                                              issue_rs2[3:0]);
                    // Illegal instructions write nothing, so they never wait for a drain.
                    state_d   = (illegal_d || (cnt[issue_funct7[1:0]] == '0)) ? StWrite : StDrain;
                end
            end
            StDrain: if (cnt[rca] == '0) state_d = StWrite;
            StWrite: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cfg_d = cfg_q;
        if ((state_q == StWrite) && !illegal_q) begin
            case (f3_q)
                CPU_REG: begin
                    if (rs1_q[3])      cfg_d[rca].src[port]     = rs2_q;
                    else if (rs1_q[4]) cfg_d[rca].dst_fb[port]  = rs2_q;
                    else               cfg_d[rca].dst_nfb[port] = rs2_q;
                end
                GRID_MUX: cfg_d[rca].grid[rs1_q[6:0]] = rs2_q[2:0];
                IO_MUX:   cfg_d[rca].io[rs1_q[3:0]]   = rs2_q[3:0];
                RES_MUX: begin
                    if (rs1_q[3]) cfg_d[rca].res_fb[port]  = rs2_q[3:0];
                    else          cfg_d[rca].res_nfb[port] = rs2_q[3:0];
                end
                IO_USE:   cfg_d[rca].io_use = rs1_q;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            f3_q      <= '0;
            f7_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            illegal_q <= 1'b0;
            cfg_q     <= '0;
        end else begin
            state_q   <= state_d;
            f3_q      <= f3_d;
            f7_q      <= f7_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            illegal_q <= illegal_d;
            cfg_q     <= cfg_d;
        end
    end

`ifdef RCA_CFG_READBACK_EN
    logic [31:0] old_d, old_q;

    always_comb begin
        old_d = '0;
        if (!illegal_q) begin
            case (f3_q)
                CPU_REG: begin
                    if (rs1_q[3])      old_d = 32'(cfg_q[rca].src[port]);
                    else if (rs1_q[4]) old_d = 32'(cfg_q[rca].dst_fb[port]);
                    else               old_d = 32'(cfg_q[rca].dst_nfb[port]);
                end
                GRID_MUX: old_d = 32'(cfg_q[rca].grid[rs1_q[6:0]]);
                IO_MUX:   old_d = 32'(cfg_q[rca].io[rs1_q[3:0]]);
                RES_MUX:  old_d = rs1_q[3] ? 32'(cfg_q[rca].res_fb[port])
                                           : 32'(cfg_q[rca].res_nfb[port]);
                IO_USE:   old_d = 32'(cfg_q[rca].io_use);
                default:  old_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            old_q <= '0;
        end else if (state_q == StWrite) begin
            old_q <= old_d;
        end
    end

    assign cfg_old_data = (state_q == StResp) ? old_q : '0;
`endif

    for (genvar r = 0; r < NUM_RCAS; r++) begin : g_rca
        localparam int unsigned RdW  = NUM_READ_PORTS * REG_ADDR_W;
        localparam int unsigned WrW  = NUM_WRITE_PORTS * REG_ADDR_W;
        localparam int unsigned GrW  = NUM_GRID_MUXES * GRID_MUX_SEL_W;
        localparam int unsigned IoW  = NUM_IO_UNITS * IO_MUX_SEL_W;
        localparam int unsigned ResW = NUM_WRITE_PORTS * RES_MUX_SEL_W;

        rca_inflight_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i   (clk),
            .rst_i   (rst),
            .inc_i   (use_start && (use_start_rca == 2'(r))),
            .dec_i   (use_done && (use_done_rca == 2'(r))),
            .count_o (cnt[r]),
            .full_o  (rca_full[r])
        );

        assign rca_lock[r] = (state_q != StIdle) && (f7_q == 7'(r));

        assign src_reg_addr[r*RdW +: RdW]                     = cfg_q[r].src;
        assign dst_reg_addr_fb[r*WrW +: WrW]                  = cfg_q[r].dst_fb;
        assign dst_reg_addr_nfb[r*WrW +: WrW]                 = cfg_q[r].dst_nfb;
        assign grid_mux_sel[r*GrW +: GrW]                     = cfg_q[r].grid;
        assign io_mux_sel[r*IoW +: IoW]                       = cfg_q[r].io;
        assign res_mux_sel_fb[r*ResW +: ResW]                 = cfg_q[r].res_fb;
        assign res_mux_sel_nfb[r*ResW +: ResW]                = cfg_q[r].res_nfb;
        assign io_in_use[r*NUM_IO_UNITS +: NUM_IO_UNITS]      = cfg_q[r].io_use;
    end

endmodule
